// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode tracker: prefix parser, held-key vector and press/release event FIFO.
// Latency: final byte sampled at edge N, keys/FIFO update at edge N+1.
// Backpressure: ready/valid event FIFO; when full and not popped, new events are dropped and overflow sticks.
// Optional: define KBD_PREFIX_TIMEOUT_EN to abandon partial prefixes after TIMEOUT_CYCLES idle cycles.
module ps2_key_tracker #(
    parameter int                       NUM_KEYS       = 4,
    parameter logic [9*NUM_KEYS-1:0]    KEY_MAP        = {9'h16B, 9'h174, 9'h172, 9'h175},
    parameter int                       FIFO_DEPTH     = 4,
    parameter int                       TIMEOUT_CYCLES = 2500000,
    localparam int                      KEY_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                code_valid,
    input  logic [7:0]          code_byte,
    output logic [NUM_KEYS-1:0] keys,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [KEY_W-1:0]    ev_key,
    output logic                ev_make,
    output logic                overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    // Prefix parser state
    state_t         state_q, state_d;
    logic [2:0]     skip_q, skip_d;

    // Resolved code waiting to be applied to the key vector (one-cycle stage)
    logic           req_vld_q, req_vld_d;
    logic           req_ext_q, req_ext_d;
    logic           req_make_q, req_make_d;
    logic [7:0]     req_code_q, req_code_d;

    // Key vector and event FIFO
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic [KEY_W:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic                hit;
    logic [KEY_W-1:0]    hit_idx;
    logic                push, push_ok, pop, full;

`ifdef KBD_PREFIX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    // TIMEOUT_CYCLES has no effect in this build: the parser waits indefinitely.
    if (TIMEOUT_CYCLES < 0) begin : g_tmo_unused
    end
`endif

    // Prefix FSM: advances on received bytes, emits one resolve request per complete code
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        req_vld_d  = 1'b0;
        req_ext_d  = 1'b0;
        req_make_d = 1'b0;
        req_code_d = code_byte;
`ifdef KBD_PREFIX_TIMEOUT_EN
        tmo_d      = '0;
`endif
        if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (code_byte == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (code_byte == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (code_byte == 8'hE1) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'd7;
                    end else begin
                        req_vld_d  = 1'b1;
                        req_make_d = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (code_byte == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (code_byte != 8'hE0) begin
                        req_vld_d  = 1'b1;
                        req_ext_d  = 1'b1;
                        req_make_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    req_vld_d = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    req_vld_d = 1'b1;
                    req_ext_d = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_SKIP: begin
                    // Pause is E1 plus seven bytes; the seventh returns to IDLE
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef KBD_PREFIX_TIMEOUT_EN
        end else if (state_q != ST_IDLE) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_d   = '0;
                state_d = ST_IDLE;
            end
`endif
        end
    end

    // Key lookup (lowest matching index wins) and held-state / event decision
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        keys_d  = keys_q;
        push    = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_MAP[9*i +: 9] == {req_ext_q, req_code_q}) begin
                hit     = 1'b1;
                hit_idx = KEY_W'(i);
            end
        end
        if (req_vld_q && hit) begin
            if (req_make_q && !keys_q[hit_idx]) begin
                keys_d[hit_idx] = 1'b1;
                push            = 1'b1;
            end else if (!req_make_q && keys_q[hit_idx]) begin
                keys_d[hit_idx] = 1'b0;
                push            = 1'b1;
            end
        end
    end

    // Event FIFO pointers, occupancy and sticky overflow
    always_comb begin
        full    = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop     = (cnt_q != '0) && ev_ready;
        push_ok = push && (!full || pop);
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
        ovf_d   = ovf_q | (push && full && !pop);
    end

    // State registers
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            req_vld_q  <= 1'b0;
            req_ext_q  <= 1'b0;
            req_make_q <= 1'b0;
            req_code_q <= '0;
            keys_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef KBD_PREFIX_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            req_vld_q  <= req_vld_d;
            req_ext_q  <= req_ext_d;
            req_make_q <= req_make_d;
            req_code_q <= req_code_d;
            keys_q     <= keys_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
`ifdef KBD_PREFIX_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // FIFO storage; contents are only visible while occupancy is non-zero
    always_ff @(posedge clk_50) begin
        if (push_ok) begin
            mem_q[wr_q] <= {hit_idx, req_make_q};
        end
    end

    assign keys     = keys_q;
    assign ev_valid = (cnt_q != '0);
    assign ev_key   = ev_valid ? mem_q[rd_q][KEY_W:1] : '0;
    assign ev_make  = ev_valid ? mem_q[rd_q][0] : 1'b0;
    assign overflow = ovf_q;

endmodule
